// File: rtl/robo_nav_ctrl_if.sv
// Sensor sampling and command handshake bundle between the navigation controller
// and the map memory.
interface robo_nav_ctrl_if;
  logic       step;
  logic       sense_valid;
  logic       head;
  logic       left;
  logic       under;
  logic       barrier;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd;

  modport master (
    input  step, sense_valid, head, left, under, barrier, cmd_ready,
    output cmd_valid, cmd
  );

  modport slave (
    output step, sense_valid, head, left, under, barrier, cmd_ready,
    input  cmd_valid, cmd
  );
endinterface

// File: rtl/robo_nav_ctrl.sv
// Left-hand wall-following navigation controller: samples the map memory's sensors
// on each step, issues one move over valid/ready, and flags goal arrival or stall.
module robo_nav_ctrl #(
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  robo_nav_ctrl_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic              stuck,
  output logic [3:0]        stall_cnt
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CMD_W   = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [CMD_W-1:0] CMD_FWD = 2'b00;
  localparam logic [CMD_W-1:0] CMD_TL  = 2'b01;
  localparam logic [CMD_W-1:0] CMD_TR  = 2'b10;
  localparam logic [CMD_W-1:0] CMD_REM = 2'b11;

  typedef enum logic [2:0] {
    IDLE, SENSE, DECIDE, ISSUE, ISSUE2, DONE, STUCK
  } state_e;

  state_e             state_q, state_d;
  logic               head_q, head_d;
  logic               left_q, left_d;
  logic               under_q, under_d;
  logic               barrier_q, barrier_d;
  logic               left_prev_q, left_prev_d;
  logic               fwd_pend_q, fwd_pend_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               stuck_q, stuck_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               accept_c;
  logic [CNT_W-1:0]   stall_inc_c;

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      head_q      <= 1'b0;
      left_q      <= 1'b0;
      under_q     <= 1'b0;
      barrier_q   <= 1'b0;
      left_prev_q <= 1'b0;
      fwd_pend_q  <= 1'b0;
      cmd_q       <= CMD_FWD;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stuck_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      left_q      <= left_d;
      under_q     <= under_d;
      barrier_q   <= barrier_d;
      left_prev_q <= left_prev_d;
      fwd_pend_q  <= fwd_pend_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stuck_q     <= stuck_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state, decision and stall accounting
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    left_d      = left_q;
    under_d     = under_q;
    barrier_d   = barrier_q;
    left_prev_d = left_prev_q;
    fwd_pend_d  = fwd_pend_q;
    cmd_d       = cmd_q;
    stall_cnt_d = stall_cnt_q;

    accept_c    = cmd_valid_q && bus.cmd_ready;
    stall_inc_c = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.step) state_d = SENSE;
      end
      SENSE: begin
        if (bus.sense_valid) begin
          head_d    = bus.head;
          left_d    = bus.left;
          under_d   = bus.under;
          barrier_d = bus.barrier;
          state_d   = DECIDE;
        end
      end
      DECIDE: begin
        left_prev_d = left_q;
        fwd_pend_d  = 1'b0;
        state_d     = ISSUE;
        if (under_q) begin
          state_d = DONE;
        end else if (barrier_q) begin
          cmd_d = CMD_REM;
        end else if (!left_q && left_prev_q) begin
          // Wall on the left just opened: turn into the gap, then step through it
          cmd_d      = CMD_TL;
          fwd_pend_d = 1'b1;
        end else if (!head_q) begin
          cmd_d = CMD_FWD;
        end else begin
          cmd_d = CMD_TR;
        end
      end
      ISSUE, ISSUE2: begin
        if (accept_c) begin
          if (cmd_q == CMD_FWD) begin
            stall_cnt_d = '0;
            state_d     = IDLE;
          end else begin
            stall_cnt_d = stall_inc_c;
            if (32'(stall_inc_c) >= STALL_LIMIT) begin
              state_d = STUCK;
            end else if (fwd_pend_q) begin
              state_d    = ISSUE2;
              cmd_d      = CMD_FWD;
              fwd_pend_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DONE, STUCK: begin
        state_d = state_q;
      end
      default: state_d = IDLE;
    endcase

    cmd_valid_d = (state_d == ISSUE) || (state_d == ISSUE2);
    busy_d      = !((state_d == IDLE) || (state_d == DONE) || (state_d == STUCK));
    done_d      = done_q || (state_d == DONE);
    stuck_d     = stuck_q || (state_d == STUCK);
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = cmd_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign stuck         = stuck_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_robo_nav_ctrl.sv
// Self-checking bench for robo_nav_ctrl: vector table, directed corner sequences,
// and randomized steps against a rule-level reference model.
module tb_robo_nav_ctrl;
  localparam int unsigned STALL_LIM = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       busy, done, stuck;
  logic [3:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int got_q[$];
  int exp_q[$];
  int m_left_prev, m_stall, m_done, m_stuck;
  logic h, l, u, b;

  robo_nav_ctrl_if nif();

  robo_nav_ctrl #(.STALL_LIMIT(STALL_LIM)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (nif),
    .busy      (busy),
    .done      (done),
    .stuck     (stuck),
    .stall_cnt (stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic h, l, u, b;
    int   n;
    int   c0;
    int   c1;
    int   stall;
    int   done;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic junk();
    nif.head    = 1'($urandom_range(0, 1));
    nif.left    = 1'($urandom_range(0, 1));
    nif.under   = 1'($urandom_range(0, 1));
    nif.barrier = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_valid"}, int'(nif.cmd_valid), 0);
    chk({tag, "_cmd"},       int'(nif.cmd), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_stuck"},     int'(stuck), 0);
    chk({tag, "_stall"},     int'(stall_cnt), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    nif.step = 1'b0; nif.sense_valid = 1'b0; nif.cmd_ready = 1'b0;
    junk();
    #1;
    chk_reset_vals("rst");
    tick();
    tick();
    reset = 1'b1;
    m_left_prev = 0; m_stall = 0; m_done = 0; m_stuck = 0;
  endtask

  // Reference: one decision from the wall-following rules, then stall accounting
  task automatic model_step(input logic mh, ml, mu, mb);
    int seq[$];
    exp_q.delete();
    if (m_done != 0 || m_stuck != 0) return;
    if (mu) begin
      m_done = 1;
    end else if (mb) seq.push_back(3);
    else if (!ml && m_left_prev != 0) begin seq.push_back(1); seq.push_back(0); end
    else if (!mh) seq.push_back(0);
    else seq.push_back(2);
    m_left_prev = int'(ml);
    for (int i = 0; i < seq.size(); i++) begin
      exp_q.push_back(seq[i]);
      m_stall = (seq[i] == 0) ? 0 : ((m_stall < 15) ? m_stall + 1 : 15);
      if (m_stall >= int'(STALL_LIM)) begin
        m_stuck = 1;
        break;
      end
    end
  endtask

  // Drive one step and collect every accepted command until the DUT settles
  task automatic nav_step(input logic sh, sl, su, sb, input int sv_delay, input bit rnd_ready);
    bit   pend;
    int   pend_cmd;
    logic rdy;
    int   c;
    got_q.delete();
    nif.step = 1'b1;
    tick();
    nif.step = 1'b0;
    for (int i = 0; i < sv_delay; i++) begin junk(); tick(); end
    nif.sense_valid = 1'b1;
    nif.head = sh; nif.left = sl; nif.under = su; nif.barrier = sb;
    tick();
    nif.sense_valid = 1'b0;
    junk();
    pend = 1'b0;
    pend_cmd = 0;
    for (c = 0; c < 200; c++) begin
      if (!busy && !nif.cmd_valid) break;
      if (pend) begin
        chk("hold_valid", int'(nif.cmd_valid), 1);
        chk("hold_cmd", int'(nif.cmd), pend_cmd);
      end
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      nif.cmd_ready = rdy;
      if (nif.cmd_valid && rdy) got_q.push_back(int'(nif.cmd));
      pend = nif.cmd_valid && !rdy;
      pend_cmd = int'(nif.cmd);
      tick();
    end
    nif.cmd_ready = 1'b0;
    if (c >= 200) chk("nav_timeout", c, 0);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_nxfer"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_cmd"}, got_q[i], exp_q[i]);
    chk({tag, "_stall"}, int'(stall_cnt), m_stall);
    chk({tag, "_done"},  int'(done), m_done);
    chk({tag, "_stuck"}, int'(stuck), m_stuck);
    chk({tag, "_busy"},  int'(busy), 0);
  endtask

  initial begin
    //           h     l     u     b    n  c0  c1 stall done
    vt[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 0, -1, 0, 0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1,  0, 0, 0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 2, -1, 1, 0};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 3, -1, 2, 0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 2, 1,  0, 0, 0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, -1, 0, 0};
    vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 2, -1, 1, 0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 2, -1, 2, 0};
    vt[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, -1, 2, 1};
    vt[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, -1, 2, 1};

    nif.step = 1'b0; nif.sense_valid = 1'b0; nif.cmd_ready = 1'b0;
    junk();
    #2;
    do_reset();

    // Minimum latency: FORWARD accepted on the third edge after step is sampled
    nif.step = 1'b1; nif.sense_valid = 1'b1; nif.cmd_ready = 1'b1;
    nif.head = 1'b0; nif.left = 1'b1; nif.under = 1'b0; nif.barrier = 1'b0;
    tick();
    nif.step = 1'b0;
    chk("lat_e1_busy", int'(busy), 1);
    chk("lat_e1_valid", int'(nif.cmd_valid), 0);
    tick();
    nif.sense_valid = 1'b0;
    junk();
    chk("lat_e2_valid", int'(nif.cmd_valid), 0);
    tick();
    chk("lat_e3_valid", int'(nif.cmd_valid), 1);
    chk("lat_e3_cmd", int'(nif.cmd), 0);
    tick();
    nif.cmd_ready = 1'b0;
    chk("lat_e4_valid", int'(nif.cmd_valid), 0);
    chk("lat_e4_busy", int'(busy), 0);
    chk("lat_e4_stall", int'(stall_cnt), 0);

    // Reset while a command is presented
    nav_step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("mid_pre_n", got_q.size(), 1);
    chk("mid_pre_stall", int'(stall_cnt), 1);
    nif.step = 1'b1;
    tick();
    nif.step = 1'b0;
    nif.sense_valid = 1'b1;
    nif.head = 1'b1; nif.left = 1'b1; nif.under = 1'b0; nif.barrier = 1'b0;
    tick();
    nif.sense_valid = 1'b0;
    tick();
    chk("mid_valid", int'(nif.cmd_valid), 1);
    chk("mid_cmd", int'(nif.cmd), 2);
    reset = 1'b0;
    #1;
    chk_reset_vals("mid");
    tick();
    reset = 1'b1;
    nav_step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("mid_post_n", got_q.size(), 1);
    if (got_q.size() > 0) chk("mid_post_cmd", got_q[0], 2);
    chk("mid_post_stall", int'(stall_cnt), 1);

    // Vector table from a fresh reset
    do_reset();
    for (int i = 0; i < 10; i++) begin
      nav_step(vt[i].h, vt[i].l, vt[i].u, vt[i].b, i % 3, 1'b0);
      chk($sformatf("tbl%0d_n", i), got_q.size(), vt[i].n);
      if (got_q.size() > 0) chk($sformatf("tbl%0d_c0", i), got_q[0], vt[i].c0);
      if (got_q.size() > 1) chk($sformatf("tbl%0d_c1", i), got_q[1], vt[i].c1);
      chk($sformatf("tbl%0d_stall", i), int'(stall_cnt), vt[i].stall);
      chk($sformatf("tbl%0d_done", i), int'(done), vt[i].done);
    end

    // Backpressure with an ignored step during the stall and on the accept edge
    do_reset();
    nif.step = 1'b1;
    tick();
    nif.step = 1'b0;
    nif.sense_valid = 1'b1;
    nif.head = 1'b1; nif.left = 1'b1; nif.under = 1'b0; nif.barrier = 1'b0;
    tick();
    nif.sense_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), int'(nif.cmd_valid), 1);
      chk($sformatf("bp%0d_cmd", i), int'(nif.cmd), 2);
      nif.step = (i == 2);
      tick();
    end
    nif.step = 1'b1;
    nif.cmd_ready = 1'b1;
    chk("bp_final_valid", int'(nif.cmd_valid), 1);
    tick();
    nif.step = 1'b0;
    nif.cmd_ready = 1'b0;
    chk("bp_after_valid", int'(nif.cmd_valid), 0);
    chk("bp_after_stall", int'(stall_cnt), 1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_idle%0d_busy", i), int'(busy), 0);
      tick();
    end

    // Goal beats barrier; later steps do nothing
    do_reset();
    nav_step(1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    chk("goal_n", got_q.size(), 0);
    chk("goal_done", int'(done), 1);
    for (int i = 0; i < 2; i++) begin
      nav_step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
      chk($sformatf("goal_after%0d_n", i), got_q.size(), 0);
      chk($sformatf("goal_after%0d_done", i), int'(done), 1);
      chk($sformatf("goal_after%0d_stuck", i), int'(stuck), 0);
    end

    // Stall limit: eight right turns then stuck
    do_reset();
    for (int s = 0; s < 8; s++) begin
      nav_step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      chk($sformatf("stall%0d_n", s), got_q.size(), 1);
      if (got_q.size() > 0) chk($sformatf("stall%0d_cmd", s), got_q[0], 2);
      chk($sformatf("stall%0d_cnt", s), int'(stall_cnt), s + 1);
      chk($sformatf("stall%0d_stuck", s), int'(stuck), (s == 7) ? 1 : 0);
    end
    nav_step(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("stuck_after_n", got_q.size(), 0);
    chk("stuck_after_stuck", int'(stuck), 1);
    chk("stuck_after_cnt", int'(stall_cnt), 8);

    // Randomized steps against the reference model
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int s = 0; s < 30; s++) begin
        h = 1'($urandom_range(0, 1));
        l = 1'($urandom_range(0, 1));
        u = ($urandom_range(0, 19) == 0);
        b = ($urandom_range(0, 7) == 0);
        model_step(h, l, u, b);
        nav_step(h, l, u, b, $urandom_range(0, 2), 1'b1);
        cmp_model($sformatf("rnd%0d_%0d", r, s));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/robo_nav_ctrl.md
# robo_nav_ctrl

Autonomous navigation controller for the robot in the map memory. It sits directly upstream of the map memory block. On each `step` request it samples the memory's sensor outputs (`head`, `left`, `under`, `barrier`) and decides one move using a left-hand wall-following rule. It then issues that move as a command over a valid/ready handshake, which the memory applies to the robot row, column and orientation. It also detects goal arrival and stalls (spinning in place).

## Interface
- `STALL_LIMIT`, default 8: consecutive non-forward commands that force the STUCK state (1..15).
- `clock` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset asserted).
- `step` in 1: one-cycle pulse requesting one navigation decision.
- `sense_valid` in 1: sensor bits are valid this cycle.
- `head` in 1: cell ahead is wall/edge.
- `left` in 1: cell to the left is wall/edge.
- `under` in 1: robot stands on the goal cell.
- `barrier` in 1: removable barrier ahead.
- `cmd_ready` in 1: memory accepts the command this cycle.
- `cmd_valid` out 1: command presented.
- `cmd` out 2: 00 FORWARD, 01 TURN_LEFT, 10 TURN_RIGHT, 11 REMOVE.
- `busy` out 1: 1 whenever the state is not IDLE, DONE or STUCK.
- `done` out 1: sticky, goal reached.
- `stuck` out 1: sticky, stall limit reached.
- `stall_cnt` out 4: current consecutive non-forward count.

## Operation
- States: IDLE, SENSE, DECIDE, ISSUE, ISSUE2, DONE, STUCK.
- IDLE:
  - `step`=1 → SENSE.
  - A `step` in any other state is ignored. It is not queued.
- SENSE:
  - Waits for `sense_valid`=1, with no timeout.
  - In that cycle it latches the four sensors, then → DECIDE.
- DECIDE: one cycle, priority order:
  - `under`=1 → DONE.
  - `barrier`=1 → REMOVE.
  - `left`=0 and `left_prev`=1 → TURN_LEFT, with a pending FORWARD.
  - `head`=0 → FORWARD.
  - Otherwise → TURN_RIGHT.
  - Every case except DONE goes → ISSUE.
  - `left_prev` is loaded with the latched `left` in every DECIDE cycle.
- ISSUE:
  - `cmd_valid`=1 and `cmd` is held stable until `cmd_ready`=1.
  - On acceptance: if a FORWARD is pending → ISSUE2, else → IDLE.
- ISSUE2:
  - Presents FORWARD under the same handshake rules.
  - On acceptance → IDLE.
- Stall counter (`stall_cnt`, updated on each accepted command):
  - FORWARD clears it to 0.
  - TURN_LEFT, TURN_RIGHT and REMOVE increment it, saturating at 15.
  - After the increment, if `stall_cnt` ≥ `STALL_LIMIT` the next state is STUCK instead of IDLE/ISSUE2.
- DONE and STUCK:
  - Absorbing states; only `reset` leaves them.
  - `cmd_valid`=0 in both.
  - DONE sets `done`=1; STUCK sets `stuck`=1.
- `cmd_valid` never drops without acceptance, except under reset.

## Timing
- Reset values (asynchronous, immediate while `reset`=0):
  - State = IDLE.
  - `cmd_valid`=0, `cmd`=00, `busy`=0, `done`=0, `stuck`=0, `stall_cnt`=0, `left_prev`=0.
- Latency:
  - `step` at edge N → SENSE from N+1.
  - If `sense_valid` is already high at N+1, DECIDE is at N+2 and `cmd_valid` rises at N+3.
  - Minimum step-to-accept is 3 cycles with `cmd_ready` tied high.
- Handshake: transfer happens on the edge where `cmd_valid`&&`cmd_ready`. `cmd_ready` high while `cmd_valid`=0 has no effect.
- TURN_LEFT+FORWARD takes at least two accepted transfers in consecutive cycles.
- A `step` arriving on the same edge as the final accept is ignored, because the state is not yet IDLE. The next `step` must arrive with the state in IDLE.
- Sensor bits outside the `sense_valid` cycle are don't-care.
- A reset asserted mid-ISSUE drops `cmd_valid` immediately; no transfer is counted.
- All outputs are registered.

## Test plan
- Reset mid-handshake:
  - Stimulus: reset held low, then released; `step` pulse; `sense_valid` with head=0, left=1; `cmd_ready`=1.
  - Required: FORWARD transferred 3 cycles after `step`; `stall_cnt`=0; back to IDLE.
  - Repeat with `reset` dropped while `cmd_valid`=1: all outputs return to reset values the same cycle.
- Left-opening:
  - Stimulus: step 1 with left=1, head=0, then step 2 with left=0, head=1.
  - Required: step 2 issues TURN_LEFT, then FORWARD in consecutive transfers; `stall_cnt` goes 1 → 0.
- Backpressure:
  - Stimulus: head=1, left=1; `cmd_ready` held 0 for 5 cycles.
  - Required: `cmd_valid` stays 1 and `cmd`=10 is stable for 5 cycles, then one transfer.
  - A `step` pulsed during the stall is ignored.
- Barrier priority:
  - Stimulus: barrier=1 and head=1 together.
  - Required: REMOVE (11) issued, not TURN_RIGHT.
- Goal:
  - Stimulus: under=1 together with barrier=1.
  - Required: DONE, `done`=1, no command issued; later `step` pulses produce nothing until reset.
- Stall, with STALL_LIMIT=8:
  - Stimulus: 8 steps with head=1, left=1.
  - Required: 8 TURN_RIGHT transfers; `stall_cnt`=8; `stuck`=1 after the 8th accept; no further commands.
